spram_frame_arbiter: RTL and testbench
======================================

Name: spram_frame_arbiter

Overview:
- Shares one SP256K single-port RAM between a streaming pixel writer (camera side) and a random-access reader (VGA side), all on one clock.
- Generalises the single-address, button-driven SPRAM write to parametrised width and depth, with sequential frame addressing, a write FIFO, read-priority arbitration and drop accounting.
- Sits between the camera reader/VGA timing logic and the SPRAM macro. It drives the macro's AD/DI/WE/MASKWE pins and takes its DO.

Parameters:
- ADDR_W, 14, RAM word-address width.
- DATA_W, 16, pixel/word width (1..16); zero-extended onto RAM data.
- FRAME_WORDS, 16384, words per frame; write address wraps at FRAME_WORDS-1 (2..2^ADDR_W).
- FIFO_DEPTH, 4, write FIFO entries (power of two, >=2).

Ports:
- clk, in, 1, system clock (25 MHz PLL output).
- rst_n, in, 1, synchronous active-low reset.
- wr_valid, in, 1, pixel present this cycle.
- wr_sof, in, 1, qualifies wr_valid; this pixel is frame word 0.
- wr_data, in, DATA_W, pixel data.
- wr_ready, out, 1, FIFO not full (advisory; the camera cannot stall).
- rd_en, in, 1, read request this cycle.
- rd_addr, in, ADDR_W, read word address.
- rd_data, out, DATA_W, read data (low DATA_W bits of ram_dout).
- rd_valid, out, 1, rd_data valid.
- ram_addr, out, ADDR_W, to SPRAM AD.
- ram_din, out, 16, to SPRAM DI.
- ram_we, out, 1, to SPRAM WE.
- ram_maskwe, out, 4, to SPRAM MASKWE. Constant 4'b1111.
- ram_dout, in, 16, from SPRAM DO.
- frame_wrap, out, 1, one-cycle pulse when the write address wraps to 0.
- overflow, out, 1, sticky: a pixel was dropped.
- ovf_clr, in, 1, clears overflow and drop_cnt.
- drop_cnt, out, 8, dropped-pixel count, saturates at 255.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO empty; wr_ready=1; wr address counter=0.
  - ram_we=0, ram_addr=0, ram_din=0.
  - rd_valid=0, frame_wrap=0, overflow=0, drop_cnt=0.
  - In-flight reads are discarded: rd_valid stays 0 for the two cycles after reset is released.
- Push path:
  - A push is accepted when wr_valid=1 and the FIFO is not full at the start of the cycle. A pop in the same cycle does not make room.
  - Each FIFO entry holds {address, data}. The address is assigned at push: 0 if wr_sof, otherwise the counter value.
  - The counter then becomes assigned+1. If assigned=FRAME_WORDS-1, the counter becomes 0 and frame_wrap pulses the next cycle.
- Drop:
  - A drop occurs when wr_valid=1 and the FIFO is full. The data is lost.
  - overflow is set and drop_cnt increments (saturating at 255).
  - The address counter still advances, following the same sof and wrap rules, so later pixels keep their frame position.
- ovf_clr=1 clears overflow and drop_cnt. If a drop happens in the same cycle, the clear wins and the drop is not counted.
- Arbitration, per cycle, with registered RAM controls:
  - rd_en=1: next cycle ram_addr=rd_addr, ram_we=0. The FIFO does not pop.
  - Else, FIFO non-empty: pop the head. Next cycle ram_addr=entry address, ram_din=entry data zero-extended to 16 bits, ram_we=1.
  - Else: ram_we=0; ram_addr holds its previous value.
- Read latency:
  - rd_en in cycle N gives the RAM address in N+1; SPRAM DO is valid in N+2.
  - rd_valid=1 in cycle N+2, with rd_data = ram_dout[DATA_W-1:0].
  - Back-to-back reads are fully pipelined, one per cycle.
- Read/write ordering:
  - A read issued while a write to the same address is still queued returns the old data.
  - A read issued at least one cycle after the write's ram_we cycle returns the new data.
- Writes starve while rd_en is held high. The FIFO then fills and drops occur.
- wr_sof without wr_valid is ignored.

Test Plan:
1. Reset, then 8 pushes (data 0x0001..0x0008, first with sof) with rd_en=0. Required: ram_we pulses at addresses 0..7 with matching ram_din; drop_cnt=0.
2. rd_en=1 for addresses 3,4,5 in consecutive cycles after test 1. Required: rd_valid for 3 cycles starting 2 cycles later; rd_data 0x0004, 0x0005, 0x0006.
3. FRAME_WORDS=16: push 17 pixels, sof only on the first. Required: the 17th pixel is written to address 0; frame_wrap pulses exactly once.
4. Hold rd_en=1 and push 6 pixels, FIFO_DEPTH=4. Required: wr_ready falls after 4 pushes; overflow=1; drop_cnt=2. After rd_en drops, 4 writes land at addresses 0..3. The next pushed pixel goes to address 6.
5. Drop coincident with ovf_clr=1. Required: overflow=0 and drop_cnt=0 next cycle. Also force 300 drops without a clear: drop_cnt saturates at 255.
6. Assert rst_n=0 one cycle after an rd_en and with the FIFO holding 3 entries. Required: no rd_valid and no ram_we after release; the next sof pixel is written to address 0.

Source files
------------

// File: rtl/spram_frame_arbiter.sv
// Shares one SP256K between a streaming frame writer (via a small FIFO)
// and a read-priority random-access reader, with drop accounting.
module spram_frame_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 16,
    parameter int FRAME_WORDS = 16384,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic              wr_sof,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_din,
    output logic              ram_we,
    output logic [3:0]        ram_maskwe,
    input  logic [15:0]       ram_dout,
    output logic              frame_wrap,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic [7:0]        drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] r_fa [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fd [FIFO_DEPTH];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [PW:0]       r_cnt;
    logic [ADDR_W-1:0] r_wa;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [15:0]       r_ram_din;
    logic              r_ram_we;
    logic              r_rd_p1;
    logic              r_rd_v;
    logic              r_wrap;
    logic              r_ovf;
    logic [7:0]        r_drop;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [ADDR_W-1:0] w_asg;
    logic              w_last;
    logic              w_unused;

    assign w_full  = (r_cnt == FULL_CNT);
    assign w_empty = (r_cnt == '0);
    // Fullness is judged at the start of the cycle; a same-cycle pop never frees a slot.
    assign w_push  = wr_valid & ~w_full;
    assign w_drop  = wr_valid & w_full;
    assign w_pop   = ~rd_en & ~w_empty;
    assign w_asg   = wr_sof ? '0 : r_wa;
    assign w_last  = (w_asg == LAST);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fa[r_wp] <= w_asg;
            r_fd[r_wp] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (PW + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (PW + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Dropped pixels still advance the counter so later pixels keep their position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wa   <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= wr_valid & w_last;
            if (wr_valid) r_wa <= w_last ? '0 : w_asg + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (ovf_clr) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_ram_we   <= 1'b0;
            r_rd_p1    <= 1'b0;
            r_rd_v     <= 1'b0;
        end else begin
            r_rd_p1 <= rd_en;
            r_rd_v  <= r_rd_p1;
            if (rd_en) begin
                r_ram_addr <= rd_addr;
                r_ram_we   <= 1'b0;
            end else if (!w_empty) begin
                r_ram_addr <= r_fa[r_rp];
                r_ram_din  <= 16'(r_fd[r_rp]);
                r_ram_we   <= 1'b1;
            end else begin
                r_ram_we <= 1'b0;
            end
        end
    end

    assign w_unused   = ^ram_dout;
    assign wr_ready   = ~w_full;
    assign rd_data    = ram_dout[DATA_W-1:0];
    assign rd_valid   = r_rd_v;
    assign ram_addr   = r_ram_addr;
    assign ram_din    = r_ram_din;
    assign ram_we     = r_ram_we;
    assign ram_maskwe = 4'b1111;
    assign frame_wrap = r_wrap;
    assign overflow   = r_ovf;
    assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_spram_frame_arbiter.sv
// Bench for spram_frame_arbiter: vector table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_spram_frame_arbiter;

    localparam int AW    = 14;
    localparam int DW    = 12;
    localparam int FW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_sof = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_din;
    logic          ram_we;
    logic [3:0]    ram_maskwe;
    logic [15:0]   ram_dout = '0;
    logic          frame_wrap;
    logic          overflow;
    logic          ovf_clr = 1'b0;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    spram_frame_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_data(wr_data),
        .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_maskwe(ram_maskwe), .ram_dout(ram_dout),
        .frame_wrap(frame_wrap), .overflow(overflow),
        .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
    );

    // SPRAM behaviour: registered read, write on WE
    logic [15:0] mem [1 << AW];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    ent_t        q[$];
    logic [15:0] refmem [1 << AW];
    int          m_cnt;
    logic        e_we, e_rdv, e_fw, e_ovf, p_rd;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_din;
    logic [DW-1:0] e_rdd;
    int            e_drop;

    wr_t wlog[$];
    int  fw_seen;
    int  rdv_seen;

    task automatic model_step();
        bit full, empty, drop;
        int a;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            m_cnt = 0; e_we = 0; e_addr = '0; e_din = '0;
            e_rdv = 0; p_rd = 0; e_fw = 0; e_ovf = 0; e_drop = 0;
            return;
        end
        e_rdv = p_rd;
        if (p_rd) e_rdd = refmem[e_addr][DW-1:0];
        if (e_we) refmem[e_addr] = e_din;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        drop  = 0;
        if (rd_en) begin
            e_addr = rd_addr;
            e_we   = 0;
        end else if (!empty) begin
            e = q.pop_front();
            e_addr = e.a;
            e_din  = {4'b0, e.d};
            e_we   = 1;
        end else begin
            e_we = 0;
        end
        p_rd = rd_en;
        e_fw = 0;
        if (wr_valid) begin
            a = wr_sof ? 0 : m_cnt;
            e_fw = (a == FW - 1);
            m_cnt = e_fw ? 0 : a + 1;
            if (full) drop = 1;
            else q.push_back('{AW'(a), wr_data});
        end
        if (ovf_clr) begin
            e_ovf = 0;
            e_drop = 0;
        end else if (drop) begin
            e_ovf = 1;
            if (e_drop < 255) e_drop++;
        end
    endtask

    task automatic check_model();
        chk("m_rd_valid", rd_valid, e_rdv);
        if (e_rdv) chk("m_rd_data", rd_data, e_rdd);
        chk("m_ram_we", ram_we, e_we);
        chk("m_ram_addr", ram_addr, e_addr);
        if (e_we) chk("m_ram_din", ram_din, e_din);
        chk("m_wr_ready", wr_ready, q.size() < DEPTH);
        chk("m_frame_wrap", frame_wrap, e_fw);
        chk("m_overflow", overflow, e_ovf);
        chk("m_drop_cnt", drop_cnt, e_drop);
        chk("m_maskwe", ram_maskwe, 4'hF);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (rst_n) check_model();
        if (ram_we) wlog.push_back('{ram_addr, ram_din});
        if (frame_wrap) fw_seen++;
        if (rd_valid) rdv_seen++;
    endtask

    task automatic drv(input logic wv, input logic sof, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra, input logic clr);
        wr_valid = wv; wr_sof = sof; wr_data = wd;
        rd_en = re; rd_addr = ra; ovf_clr = clr;
    endtask

    typedef struct {
        logic          wv, sof;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] ra;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [15:0]   ed;
        logic          erdv;
        logic [DW-1:0] erd;
    } vec_t;

    function automatic vec_t mk(logic wv, logic sof, logic [DW-1:0] wd,
                                logic re, logic [AW-1:0] ra, logic ewe,
                                logic [AW-1:0] ea, logic [15:0] ed,
                                logic erdv, logic [DW-1:0] erd);
        vec_t v;
        v.wv = wv; v.sof = sof; v.wd = wd; v.re = re; v.ra = ra;
        v.ewe = ewe; v.ea = ea; v.ed = ed; v.erdv = erdv; v.erd = erd;
        return v;
    endfunction

    vec_t tv[14];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = '0;
            refmem[i] = '0;
        end
        fw_seen = 0;
        rdv_seen = 0;

        tv[0] = mk(1, 1, 12'h001, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++)
            tv[i] = mk(1, 0, DW'(i + 1), 0, 0, 1, AW'(i - 1), 16'(i), 0, 0);
        tv[8]  = mk(0, 0, 0, 0, 0, 1, 14'd7, 16'h0008, 0, 0);
        tv[9]  = mk(0, 0, 0, 1, 14'd3, 0, 0, 0, 0, 0);
        tv[10] = mk(0, 0, 0, 1, 14'd4, 0, 0, 0, 1, 12'h004);
        tv[11] = mk(0, 0, 0, 1, 14'd5, 0, 0, 0, 1, 12'h005);
        tv[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 12'h006);
        tv[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset state
        rst_n = 0;
        drv(0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_frame_wrap", frame_wrap, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1;

        // pushes 1..8 then reads of 3,4,5
        for (int i = 0; i < 14; i++) begin
            drv(tv[i].wv, tv[i].sof, tv[i].wd, tv[i].re, tv[i].ra, 0);
            cyc();
            chk($sformatf("tv%0d_we", i), ram_we, tv[i].ewe);
            if (tv[i].ewe) begin
                chk($sformatf("tv%0d_addr", i), ram_addr, tv[i].ea);
                chk($sformatf("tv%0d_din", i), ram_din, tv[i].ed);
            end
            chk($sformatf("tv%0d_rdv", i), rd_valid, tv[i].erdv);
            if (tv[i].erdv) chk($sformatf("tv%0d_rdd", i), rd_data, tv[i].erd);
        end
        chk("t1_drop_cnt", drop_cnt, 0);

        // frame wrap over 17 pixels
        wlog.delete();
        fw_seen = 0;
        for (int k = 0; k < 17; k++) begin
            drv(1, k == 0, DW'(12'h100 + k), 0, 0, 0);
            cyc();
        end
        drv(0, 0, 0, 0, 0, 0);
        repeat (3) cyc();
        chk("t3_nwrites", wlog.size(), 17);
        if (wlog.size() == 17) begin
            chk("t3_last_addr", wlog[16].a, 0);
            chk("t3_last_din", wlog[16].d, 16'h0110);
            chk("t3_wrap15", wlog[15].a, 15);
        end
        chk("t3_fw_pulses", fw_seen, 1);

        // read starvation fills FIFO and drops
        for (int k = 0; k < 6; k++) begin
            drv(1, k == 0, DW'(12'h200 + k), 1, 14'd9, 0);
            cyc();
            if (k == 2) chk("t4_ready_3", wr_ready, 1);
            if (k == 3) chk("t4_ready_4", wr_ready, 0);
        end
        chk("t4_overflow", overflow, 1);
        chk("t4_drop_cnt", drop_cnt, 2);
        wlog.delete();
        drv(0, 0, 0, 0, 0, 0);
        repeat (5) cyc();
        drv(1, 0, 12'h2AA, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0);
        repeat (3) cyc();
        chk("t4_nwrites", wlog.size(), 5);
        if (wlog.size() == 5) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t4_addr%0d", i), wlog[i].a, i);
                chk($sformatf("t4_din%0d", i), wlog[i].d, 16'h200 + i);
            end
            chk("t4_next_addr", wlog[4].a, 6);
        end

        // clear wins over coincident drop, then saturation
        for (int k = 0; k < 4; k++) begin
            drv(1, 0, DW'(k), 1, 14'd1, 0);
            cyc();
        end
        drv(1, 0, 12'h0FF, 1, 14'd1, 1);
        cyc();
        chk("t5_clr_ovf", overflow, 0);
        chk("t5_clr_cnt", drop_cnt, 0);
        for (int k = 0; k < 300; k++) begin
            drv(1, 0, DW'(k), 1, 14'd2, 0);
            cyc();
        end
        chk("t5_sat_cnt", drop_cnt, 255);
        chk("t5_sat_ovf", overflow, 1);
        drv(0, 0, 0, 0, 0, 0);
        repeat (6) cyc();
        drv(0, 0, 0, 0, 0, 1);
        cyc();
        chk("t5_clr2_cnt", drop_cnt, 0);

        // reset with a read in flight and 3 queued writes
        wlog.delete();
        for (int k = 0; k < 3; k++) begin
            drv(1, 0, DW'(12'h300 + k), 1, 14'd4, 0);
            cyc();
        end
        drv(0, 0, 0, 0, 0, 0);
        rst_n = 0;
        cyc();
        rst_n = 1;
        rdv_seen = 0;
        repeat (4) cyc();
        chk("t6_no_rdv", rdv_seen, 0);
        chk("t6_no_we", wlog.size(), 0);
        drv(1, 1, 12'h3CC, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0);
        repeat (2) cyc();
        chk("t6_nwrites", wlog.size(), 1);
        if (wlog.size() == 1) begin
            chk("t6_addr", wlog[0].a, 0);
            chk("t6_din", wlog[0].d, 16'h03CC);
        end

        // randomized traffic against the model
        for (int k = 0; k < 2000; k++) begin
            drv($urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                DW'($urandom), $urandom_range(0, 9) < 3,
                AW'($urandom_range(0, 31)), $urandom_range(0, 49) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            cyc();
        end
        rst_n = 1;
        drv(0, 0, 0, 0, 0, 0);
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
